// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: store-and-forward packet FIFO; overflowing packets are dropped whole, upstream never stalls.
module axis_packet_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  drop_pulse,
    output logic [AW:0]           pkt_count
);
    typedef enum logic {ACCEPT, DROP} state_t;
    state_t state;
    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW:0] wr_ptr, commit_ptr, rd_ptr, fill;
    logic full, wr_en, commit, rd_en, pop;
    // fill never exceeds DEPTH, so equality with DEPTH is an exact test on the wrapped difference
    assign fill     = wr_ptr - rd_ptr;
    assign full     = fill == {1'b1, {AW{1'b0}}};
    assign wr_en    = s_tvalid && state == ACCEPT && !full;
    assign commit   = wr_en && s_tlast;
    assign m_tvalid = rd_ptr != commit_ptr;
    assign {m_tlast, m_tdata} = mem[rd_ptr[AW-1:0]];
    assign rd_en    = m_tvalid && m_tready;
    assign pop      = rd_en && m_tlast;
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_count  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            if (s_tvalid && state == ACCEPT) begin
                if (!full) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (s_tlast) commit_ptr <= wr_ptr + 1'b1;
                end else begin
                    wr_ptr     <= commit_ptr;
                    drop_pulse <= 1'b1;
                    state      <= s_tlast ? ACCEPT : DROP;
                end
            end else if (s_tvalid && s_tlast) begin
                state <= ACCEPT;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            pkt_count <= pkt_count + (AW+1)'(commit) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo: directed scenarios for axis_packet_fifo; inputs driven and outputs sampled on negedge.
module tb_axis_packet_fifo;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] s_tdata = '0, m_tdata;
    logic       s_tvalid = 1'b0, s_tlast = 1'b0;
    logic       m_tvalid, m_tready = 1'b0, m_tlast, drop_pulse;
    logic [4:0] pkt_count;
    int vecs = 0, errs = 0, drop_cnt = 0, valid_cnt = 0;

    axis_packet_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .drop_pulse(drop_pulse), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (drop_pulse) drop_cnt++;
        if (m_tvalid) valid_cnt++;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic beat(input logic [7:0] d, input logic l);
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vecs++; if (m_tvalid !== 1'b0) begin errs++; $display("FAIL reset_mvalid: got %b want 0", m_tvalid); end
        vecs++; if (pkt_count !== 5'd0) begin errs++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
        vecs++; if (drop_pulse !== 1'b0) begin errs++; $display("FAIL reset_drop: got %b want 0", drop_pulse); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_four_beat;
        logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(exp[i], 1'b0);
            vecs++; if (m_tvalid !== 1'b0) begin errs++; $display("FAIL four_uncommitted_hidden beat%0d: got %b want 0", i, m_tvalid); end
        end
        beat(exp[3], 1'b1);
        vecs++; if (pkt_count !== 5'd1) begin errs++; $display("FAIL four_pkt_count_1: got %0d want 1", pkt_count); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (m_tvalid !== 1'b1) begin errs++; $display("FAIL four_mvalid beat%0d: got %b want 1", i, m_tvalid); end
            vecs++; if (m_tdata !== exp[i]) begin errs++; $display("FAIL four_data beat%0d: got %h want %h", i, m_tdata, exp[i]); end
            vecs++; if (m_tlast !== (i == 3)) begin errs++; $display("FAIL four_last beat%0d: got %b want %b", i, m_tlast, i == 3); end
            @(negedge clk);
        end
        vecs++; if (m_tvalid !== 1'b0) begin errs++; $display("FAIL four_drained: got %b want 0", m_tvalid); end
        vecs++; if (pkt_count !== 5'd0) begin errs++; $display("FAIL four_pkt_count_0: got %0d want 0", pkt_count); end
    endtask

    task automatic test_single_beat;
        int d0 = drop_cnt;
        m_tready = 1'b1;
        beat(8'hA5, 1'b1);
        vecs++; if (m_tvalid !== 1'b1) begin errs++; $display("FAIL single_mvalid: got %b want 1", m_tvalid); end
        vecs++; if (m_tdata !== 8'hA5) begin errs++; $display("FAIL single_data: got %h want a5", m_tdata); end
        vecs++; if (m_tlast !== 1'b1) begin errs++; $display("FAIL single_last: got %b want 1", m_tlast); end
        @(negedge clk);
        vecs++; if (m_tvalid !== 1'b0) begin errs++; $display("FAIL single_drained: got %b want 0", m_tvalid); end
        vecs++; if (drop_cnt - d0 !== 0) begin errs++; $display("FAIL single_no_drop: got %0d want 0", drop_cnt - d0); end
    endtask

    task automatic test_overflow;
        int d0 = drop_cnt;
        m_tready = 1'b0;
        for (int i = 0; i < 12; i++) beat(8'(i + 1), i == 11);
        vecs++; if (pkt_count !== 5'd1) begin errs++; $display("FAIL ovf_pkt_count_first: got %0d want 1", pkt_count); end
        for (int i = 0; i < 4; i++) beat(8'h80 + 8'(i), 1'b0);
        vecs++; if (drop_pulse !== 1'b0) begin errs++; $display("FAIL ovf_no_early_drop: got %b want 0", drop_pulse); end
        beat(8'h84, 1'b0);
        vecs++; if (drop_pulse !== 1'b1) begin errs++; $display("FAIL ovf_drop_pulse: got %b want 1", drop_pulse); end
        vecs++; if (dut.wr_ptr !== (dut.rd_ptr + 5'd12)) begin errs++; $display("FAIL ovf_rewind: got %0d want %0d", dut.wr_ptr - dut.rd_ptr, 12); end
        beat(8'h85, 1'b1);
        vecs++; if (drop_cnt - d0 !== 1) begin errs++; $display("FAIL ovf_one_pulse: got %0d want 1", drop_cnt - d0); end
        vecs++; if (pkt_count !== 5'd1) begin errs++; $display("FAIL ovf_pkt_count: got %0d want 1", pkt_count); end
        m_tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            vecs++; if (m_tvalid !== 1'b1 || m_tdata !== 8'(i + 1) || m_tlast !== (i == 11)) begin
                errs++; $display("FAIL ovf_read beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, m_tvalid, m_tdata, m_tlast, 8'(i + 1), i == 11);
            end
            @(negedge clk);
        end
        vecs++; if (m_tvalid !== 1'b0) begin errs++; $display("FAIL ovf_drained: got %b want 0", m_tvalid); end
        vecs++; if (pkt_count !== 5'd0) begin errs++; $display("FAIL ovf_pkt_count_0: got %0d want 0", pkt_count); end
    endtask

    task automatic test_oversize;
        int d0 = drop_cnt, v0 = valid_cnt;
        m_tready = 1'b1;
        for (int i = 0; i < 20; i++) beat(8'h40 + 8'(i), i == 19);
        vecs++; if (drop_cnt - d0 !== 1) begin errs++; $display("FAIL big_one_pulse: got %0d want 1", drop_cnt - d0); end
        vecs++; if (valid_cnt - v0 !== 0) begin errs++; $display("FAIL big_no_mvalid: got %0d want 0", valid_cnt - v0); end
        for (int i = 0; i < 3; i++) beat(8'hC1 + 8'(i), i == 2);
        for (int i = 0; i < 3; i++) begin
            vecs++; if (m_tvalid !== 1'b1 || m_tdata !== 8'hC1 + 8'(i) || m_tlast !== (i == 2)) begin
                errs++; $display("FAIL big_follow beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, m_tvalid, m_tdata, m_tlast, 8'hC1 + 8'(i), i == 2);
            end
            @(negedge clk);
        end
        vecs++; if (m_tvalid !== 1'b0) begin errs++; $display("FAIL big_drained: got %b want 0", m_tvalid); end
    endtask

    task automatic test_back_to_back;
        logic       rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp [5] = '{8'hD1, 8'hD2, 8'hD2, 8'hD2, 8'hD3};
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) beat(8'hD1 + 8'(i), i == 2);
        for (int i = 0; i < 5; i++) begin
            m_tready = rdy[i];
            vecs++; if (m_tvalid !== 1'b1 || m_tdata !== exp[i] || m_tlast !== (i == 4)) begin
                errs++; $display("FAIL bp_step%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, m_tvalid, m_tdata, m_tlast, exp[i], i == 4);
            end
            @(negedge clk);
        end
        vecs++; if (m_tvalid !== 1'b0) begin errs++; $display("FAIL bp_drained: got %b want 0", m_tvalid); end
        vecs++; if (pkt_count !== 5'd0) begin errs++; $display("FAIL bp_pkt_count: got %0d want 0", pkt_count); end
    endtask

    task automatic test_reset_mid_packet;
        m_tready = 1'b0;
        beat(8'hE0, 1'b1);
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        s_tdata = 8'h03; s_tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (m_tvalid !== 1'b0) begin errs++; $display("FAIL rst_mid_mvalid: got %b want 0", m_tvalid); end
        vecs++; if (pkt_count !== 5'd0) begin errs++; $display("FAIL rst_mid_pkt_count: got %0d want 0", pkt_count); end
        @(negedge clk);
        s_tvalid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        beat(8'h5A, 1'b0);
        beat(8'h5B, 1'b1);
        vecs++; if (pkt_count !== 5'd1) begin errs++; $display("FAIL rst_after_pkt_count: got %0d want 1", pkt_count); end
        m_tready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vecs++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h5A + 8'(i) || m_tlast !== (i == 1)) begin
                errs++; $display("FAIL rst_after beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", i, m_tvalid, m_tdata, m_tlast, 8'h5A + 8'(i), i == 1);
            end
            @(negedge clk);
        end
        vecs++; if (m_tvalid !== 1'b0) begin errs++; $display("FAIL rst_after_drained: got %b want 0", m_tvalid); end
    endtask

    initial begin
        test_reset;
        test_four_beat;
        test_single_beat;
        test_overflow;
        test_oversize;
        test_back_to_back;
        test_reset_mid_packet;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
